// File: rtl/difftest_trap_pkg.sv
// Shared types and constants for the DifftestTrapEvent arbitration slice.
package difftest_trap_pkg;

    localparam int          CORE_ID_W         = 8;
    localparam logic [63:0] TRAP_TIMEOUT_CODE = 64'h0000_0000_DEAD_0001;

    typedef struct packed {
        logic        hasTrap;
        logic        hasWFI;
        logic [63:0] cycleCnt;
        logic [63:0] instrCnt;
        logic [63:0] code;
        logic [63:0] pc;
    } trap_event_t;

endpackage

// File: rtl/difftest_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins,
// wrapping around to index 0.
module difftest_rr_arbiter
    import difftest_trap_pkg::*;
#(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        // Upper segment [ptr, N) first, then the wrapped segment [0, ptr).
        for (int j = 0; j < N; j++) begin
            if (!w_found && req[j] && (j >= int'(ptr))) begin
                w_found   = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = PTR_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!w_found && req[j] && (j < int'(ptr))) begin
                w_found   = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/difftest_trap_arbiter.sv
// Serialises per-core trap/WFI events onto one DifftestTrapEvent sink and tracks halt.
// Optional per-core watchdog enabled by defining DIFFTEST_TRAP_TIMEOUT_EN.
module difftest_trap_arbiter
    import difftest_trap_pkg::*;
#(
    parameter int NUM_CORES      = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_CORES-1:0]   io_in_valid,
    output logic [NUM_CORES-1:0]   io_in_ready,
    input  logic [NUM_CORES-1:0]   io_in_hasTrap,
    input  logic [NUM_CORES-1:0]   io_in_hasWFI,
    input  logic [NUM_CORES*64-1:0] io_in_cycleCnt,
    input  logic [NUM_CORES*64-1:0] io_in_instrCnt,
    input  logic [NUM_CORES*64-1:0] io_in_code,
    input  logic [NUM_CORES*64-1:0] io_in_pc,
    output logic                   out_enable,
    output logic                   out_hasTrap,
    output logic                   out_hasWFI,
    output logic [63:0]            out_cycleCnt,
    output logic [63:0]            out_instrCnt,
    output logic [63:0]            out_code,
    output logic [63:0]            out_pc,
    output logic [CORE_ID_W-1:0]   out_coreid,
    output logic                   all_halted
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    if ((NUM_CORES < 1) || (NUM_CORES > 8)) begin : g_bad_num_cores
        $error("NUM_CORES must be in 1..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    trap_event_t            w_in_evt   [NUM_CORES];
    trap_event_t            w_slot_din [NUM_CORES];
    trap_event_t            r_slot_p0  [NUM_CORES];
    logic [NUM_CORES-1:0]   r_slot_vld_p0;
    logic [NUM_CORES-1:0]   r_halted;
    logic [NUM_CORES-1:0]   w_load;
    logic [NUM_CORES-1:0]   w_slot_load;
    logic [NUM_CORES-1:0]   w_grant;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       w_grant_idx;
    logic [PTR_W-1:0]       w_ptr_nxt;
    logic                   w_gnt_any;
    trap_event_t            w_gnt_evt;

    logic                   r_out_vld_p1;
    trap_event_t            r_out_evt_p1;
    logic [CORE_ID_W-1:0]   r_out_id_p1;
    logic                   r_all_halted;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
        assign w_in_evt[i] = '{
            hasTrap:  io_in_hasTrap[i],
            hasWFI:   io_in_hasWFI[i],
            cycleCnt: io_in_cycleCnt[64*i +: 64],
            instrCnt: io_in_instrCnt[64*i +: 64],
            code:     io_in_code[64*i +: 64],
            pc:       io_in_pc[64*i +: 64]
        };
    end

    // Halted cores stay ready so their commit stages never stall; their events are dropped.
    assign io_in_ready = ~r_slot_vld_p0 | r_halted;
    assign w_load      = io_in_valid & io_in_ready & ~r_halted;

`ifdef DIFFTEST_TRAP_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0]      r_wd_cnt   [NUM_CORES];
    logic [63:0]          r_last_pc  [NUM_CORES];
    logic [63:0]          r_last_cyc [NUM_CORES];
    logic [63:0]          r_last_ins [NUM_CORES];
    logic [NUM_CORES-1:0] w_accept;
    logic [NUM_CORES-1:0] w_wd_fire;

    assign w_accept = io_in_valid & io_in_ready;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_wd
        assign w_wd_fire[i] = (r_wd_cnt[i] == WD_LAST) & ~r_slot_vld_p0[i]
                            & ~io_in_valid[i] & ~r_halted[i];
        assign w_slot_din[i] = w_load[i] ? w_in_evt[i] : '{
            hasTrap:  1'b1,
            hasWFI:   1'b0,
            cycleCnt: r_last_cyc[i],
            instrCnt: r_last_ins[i],
            code:     TRAP_TIMEOUT_CODE,
            pc:       r_last_pc[i]
        };
    end

    assign w_slot_load = w_load | w_wd_fire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                r_wd_cnt[i]   <= '0;
                r_last_pc[i]  <= '0;
                r_last_cyc[i] <= '0;
                r_last_ins[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                // Counter saturates at the limit so a busy slot defers, not loses, the timeout.
                if (w_accept[i] || w_wd_fire[i]) begin
                    r_wd_cnt[i] <= '0;
                end else if (!r_halted[i] && (r_wd_cnt[i] != WD_LAST)) begin
                    r_wd_cnt[i] <= r_wd_cnt[i] + WD_W'(1);
                end
                if (w_load[i]) begin
                    r_last_pc[i]  <= w_in_evt[i].pc;
                    r_last_cyc[i] <= w_in_evt[i].cycleCnt;
                    r_last_ins[i] <= w_in_evt[i].instrCnt;
                end
            end
        end
    end
`else
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_din
        assign w_slot_din[i] = w_in_evt[i];
    end

    assign w_slot_load = w_load;
`endif

    difftest_rr_arbiter #(
        .N     (NUM_CORES),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req       (r_slot_vld_p0),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_gnt_any = |w_grant;
    assign w_gnt_evt = r_slot_p0[w_grant_idx];
    assign w_ptr_nxt = (w_grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : w_grant_idx + PTR_W'(1);

    // Stage p0: holding slots (payload only written on load, valid bit carries state).
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_slot_load[i]) begin
                r_slot_p0[i] <= w_slot_din[i];
            end
        end
    end

    // Stage p1: grant edge updates slots, halt, pointer and the sink registers together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_slot_vld_p0 <= '0;
            r_halted      <= '0;
            r_rr_ptr      <= '0;
            r_all_halted  <= 1'b0;
            r_out_vld_p1  <= 1'b0;
            r_out_evt_p1  <= '0;
            r_out_id_p1   <= '0;
        end else begin
            r_slot_vld_p0 <= (r_slot_vld_p0 & ~w_grant) | w_slot_load;
            r_halted      <= r_halted | (w_grant & {NUM_CORES{w_gnt_evt.hasTrap}});
            r_all_halted  <= &r_halted;
            r_out_vld_p1  <= w_gnt_any;
            if (w_gnt_any) begin
                r_rr_ptr     <= w_ptr_nxt;
                r_out_evt_p1 <= w_gnt_evt;
                r_out_id_p1  <= CORE_ID_W'(w_grant_idx);
            end
        end
    end

    assign out_enable   = r_out_vld_p1;
    assign out_hasTrap  = r_out_evt_p1.hasTrap;
    assign out_hasWFI   = r_out_evt_p1.hasWFI;
    assign out_cycleCnt = r_out_evt_p1.cycleCnt;
    assign out_instrCnt = r_out_evt_p1.instrCnt;
    assign out_code     = r_out_evt_p1.code;
    assign out_pc       = r_out_evt_p1.pc;
    assign out_coreid   = r_out_id_p1;
    assign all_halted   = r_all_halted;

endmodule

// File: tb/tb_difftest_trap_arbiter.sv
// Scoreboard bench for difftest_trap_arbiter: directed events, queued expectations.
module tb_difftest_trap_arbiter;
    import difftest_trap_pkg::*;

    localparam int NC  = 2;
    localparam int TMO = 16;

    typedef struct {
        logic [7:0]  id;
        trap_event_t ev;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NC-1:0]     in_valid;
    trap_event_t       drv_ev [NC];
    logic [NC-1:0]     has_trap, has_wfi;
    logic [NC*64-1:0]  cyc_bus, ins_bus, code_bus, pc_bus;

    logic [NC-1:0]     in_ready;
    logic              out_enable, out_hasTrap, out_hasWFI;
    logic [63:0]       out_cycleCnt, out_instrCnt, out_code, out_pc;
    logic [7:0]        out_coreid;
    logic              all_halted;

    exp_t sb [$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            has_trap[i]             = drv_ev[i].hasTrap;
            has_wfi[i]              = drv_ev[i].hasWFI;
            cyc_bus[64*i +: 64]     = drv_ev[i].cycleCnt;
            ins_bus[64*i +: 64]     = drv_ev[i].instrCnt;
            code_bus[64*i +: 64]    = drv_ev[i].code;
            pc_bus[64*i +: 64]      = drv_ev[i].pc;
        end
    end

    difftest_trap_arbiter #(
        .NUM_CORES      (NC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .io_in_valid    (in_valid),
        .io_in_ready    (in_ready),
        .io_in_hasTrap  (has_trap),
        .io_in_hasWFI   (has_wfi),
        .io_in_cycleCnt (cyc_bus),
        .io_in_instrCnt (ins_bus),
        .io_in_code     (code_bus),
        .io_in_pc       (pc_bus),
        .out_enable     (out_enable),
        .out_hasTrap    (out_hasTrap),
        .out_hasWFI     (out_hasWFI),
        .out_cycleCnt   (out_cycleCnt),
        .out_instrCnt   (out_instrCnt),
        .out_code       (out_code),
        .out_pc         (out_pc),
        .out_coreid     (out_coreid),
        .all_halted     (all_halted)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic trap_event_t mk(input logic t, input logic w, input logic [63:0] cyc,
                                       input logic [63:0] ins, input logic [63:0] cd,
                                       input logic [63:0] pc);
        mk = '{hasTrap: t, hasWFI: w, cycleCnt: cyc, instrCnt: ins, code: cd, pc: pc};
    endfunction

    task automatic push(input logic [7:0] id, input trap_event_t e);
        exp_t x;
        x.id = id;
        x.ev = e;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive events on the cores in mask, holding each until its handshake completes.
    task automatic issue(input logic [NC-1:0] mask, input trap_event_t e0, input trap_event_t e1);
        logic [NC-1:0] pend;
        logic [NC-1:0] rdy;
        int n;
        drv_ev[0] = e0;
        drv_ev[1] = e1;
        pend      = mask;
        in_valid  = mask;
        n         = 0;
        while (pend != '0 && n < 50) begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            #1;
            pend     = pend & ~rdy;
            in_valid = pend;
            n++;
        end
        if (pend != '0) begin
            n_checks++;
            n_err++;
            $display("FAIL issue_timeout actual_pending=%b required=00", pend);
        end
        in_valid = '0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clock) begin
        if (!reset && out_enable) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_event actual_coreid=%0d actual_pc=%h required=no_event",
                         out_coreid, out_pc);
            end else begin
                mon_e = sb.pop_front();
                check("mon_coreid", 64'(out_coreid), 64'(mon_e.id));
                check("mon_hasTrap", 64'(out_hasTrap), 64'(mon_e.ev.hasTrap));
                check("mon_hasWFI", 64'(out_hasWFI), 64'(mon_e.ev.hasWFI));
                check("mon_cycleCnt", out_cycleCnt, mon_e.ev.cycleCnt);
                check("mon_instrCnt", out_instrCnt, mon_e.ev.instrCnt);
                check("mon_code", out_code, mon_e.ev.code);
                check("mon_pc", out_pc, mon_e.ev.pc);
            end
        end
    end

    initial begin
        trap_event_t idle, e, a0, a1, b0, b1, t0, t1, n0, ra, rb;
        idle      = mk(1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
        drv_ev[0] = idle;
        drv_ev[1] = idle;
        in_valid  = '0;
        reset     = 1'b1;
        repeat (3) tick();
        check("rst_out_enable", 64'(out_enable), 64'd0);
        check("rst_ready", 64'(in_ready), 64'h3);
        check("rst_all_halted", 64'(all_halted), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_coreid", 64'(out_coreid), 64'd0);
        reset = 1'b0;

`ifdef DIFFTEST_TRAP_TIMEOUT_EN
        e = mk(1'b0, 1'b0, 64'h40, 64'h20, 64'd0, 64'h8000_0100);
        push(8'd1, e);
        push(8'd0, mk(1'b1, 1'b0, 64'd0, 64'd0, TRAP_TIMEOUT_CODE, 64'd0));
        push(8'd1, mk(1'b1, 1'b0, 64'h40, 64'h20, TRAP_TIMEOUT_CODE, 64'h8000_0100));
        issue(2'b10, idle, e);
        repeat (40) tick();
        check("tmo_drain", 64'(sb.size()), 64'd0);
        check("tmo_all_halted", 64'(all_halted), 64'd1);
`else
        // Single event: two cycles from accept to strobe.
        e = mk(1'b0, 1'b0, 64'd5, 64'd3, 64'd0, 64'h8000_0000);
        push(8'd0, e);
        issue(2'b01, e, idle);
        check("lat_e0", 64'(out_enable), 64'd0);
        tick();
        check("lat_e1", 64'(out_enable), 64'd1);
        check("single_all_halted", 64'(all_halted), 64'd0);
        drain("single_drain");

        // Backpressure on core 1 with valid held high; every other cycle is accepted.
        in_valid = 2'b10;
        for (int k = 0; k < 8; k++) begin
            drv_ev[1] = mk(1'b0, 1'b0, 64'(k), 64'(k + 100), 64'h3, 64'h9000_0000 + 64'(k));
            @(negedge clock);
            check("bp_ready", 64'(in_ready[1]), (k % 2 == 0) ? 64'd1 : 64'd0);
            if (k % 2 == 0) push(8'd1, drv_ev[1]);
            tick();
        end
        in_valid = '0;
        drain("bp_drain");

        // Contention: both cores every opportunity, alternating grants.
        a0 = mk(1'b0, 1'b0, 64'h10, 64'h11, 64'h1, 64'h8000_1000);
        b0 = mk(1'b0, 1'b0, 64'h20, 64'h21, 64'h2, 64'h8000_2000);
        a1 = mk(1'b0, 1'b1, 64'h12, 64'h13, 64'h1, 64'h8000_1004);
        b1 = mk(1'b0, 1'b0, 64'h22, 64'h23, 64'h2, 64'h8000_2004);
        push(8'd0, a0);
        push(8'd1, b0);
        push(8'd0, a1);
        push(8'd1, b1);
        issue(2'b11, a0, b0);
        issue(2'b11, a1, b1);
        drain("cont_drain");

        // Halt: core 0 trap, then its later events vanish; core 1 trap halts all.
        t0 = mk(1'b1, 1'b0, 64'h30, 64'h31, 64'd0, 64'h8000_3000);
        push(8'd0, t0);
        issue(2'b01, t0, idle);
        drain("halt0_drain");
        n0 = mk(1'b0, 1'b0, 64'h32, 64'h33, 64'h5, 64'h8000_3004);
        issue(2'b01, n0, idle);
        check("halt_ready0", 64'(in_ready[0]), 64'd1);
        repeat (4) tick();
        t1 = mk(1'b1, 1'b0, 64'h40, 64'h41, 64'h7, 64'h8000_4000);
        push(8'd1, t1);
        issue(2'b10, idle, t1);
        tick();
        check("halt_strobe", 64'(out_enable), 64'd1);
        check("halt_all_pre", 64'(all_halted), 64'd0);
        tick();
        check("halt_all_post", 64'(all_halted), 64'd1);
        drain("halt1_drain");

        // Reset while one event is strobing and the other slot is still full.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_all_halted", 64'(all_halted), 64'd0);
        ra = mk(1'b0, 1'b0, 64'h50, 64'h51, 64'h9, 64'h8000_5000);
        rb = mk(1'b0, 1'b0, 64'h60, 64'h61, 64'h9, 64'h8000_6000);
        issue(2'b11, ra, rb);
        tick();
        reset = 1'b1;
        #1;
        check("rst_mid_enable", 64'(out_enable), 64'd0);
        check("rst_mid_ready", 64'(in_ready), 64'h3);
        check("rst_mid_pc", out_pc, 64'd0);
        @(negedge clock);
        #1;
        reset = 1'b0;
        repeat (6) tick();
        check("rst_post_enable", 64'(out_enable), 64'd0);
        check("rst_post_ready", 64'(in_ready), 64'h3);
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
